move_entry: RTL and testbench

MOVE_ENTRY -- requirements
Module: move_entry

---
 rtl/move_entry.sv | 152 +++++++++++++++
 tb/tb_move_entry.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_entry.sv
// Move-entry front end: synchronizes and debounces the enter button, then hands a validated move to the game core.
// enter rises one cycle after the press event; an unaccepted move times out into a one-cycle reject pulse.
module move_entry #(
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic [2:0] sw_move,
    input  logic       ready,
    input  logic       gameover,
    output logic       enter,
    output logic [2:0] move,
    output logic       reject,
    output logic [7:0] turns,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, ACK, REJ} state_t;

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [2:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic       gov_q, gov_d;
    logic       db_q, db_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       press_q, press_d;
    state_t     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] move_q, move_d;
    logic [7:0] turns_q, turns_d;
    logic       enter_q, enter_d;
    logic       reject_q, reject_d;
    logic       busy_q, busy_d;
    logic       accept_evt;

    always_comb begin
        btn_s1_d = btn_raw;
        btn_s2_d = btn_s1_q;
        sw_s1_d  = sw_move;
        sw_s2_d  = sw_s1_q;
        gov_d    = gameover;

        // Level flips on the DEBOUNCE-th consecutive differing sample.
        db_d     = db_q;
        db_cnt_d = 8'd0;
        press_d  = 1'b0;
        if (btn_s2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d    = ~db_q;
                press_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end

        state_d    = state_q;
        tmo_d      = tmo_q;
        move_d     = move_q;
        accept_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_q && ready) begin
                    if (sw_s2_q >= 3'd1 && sw_s2_q <= 3'd5) begin
                        move_d  = sw_s2_q;
                        tmo_d   = 8'd0;
                        state_d = DRIVE;
                    end else begin
                        state_d = REJ;
                    end
                end
            end
            DRIVE: begin
                tmo_d = tmo_q + 8'd1;
                if (!ready) begin
                    state_d    = ACK;
                    accept_evt = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = REJ;
                end
            end
            ACK: begin
                if (ready) begin
                    state_d = IDLE;
                end
            end
            REJ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh game over wins over a move accepted in the same cycle.
        turns_d = turns_q;
        if (gameover && !gov_q) begin
            turns_d = 8'd0;
        end else if (accept_evt && turns_q != 8'hFF) begin
            turns_d = turns_q + 8'd1;
        end

        enter_d  = (state_d == DRIVE);
        reject_d = (state_d == REJ);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            sw_s1_q  <= 3'd0;
            sw_s2_q  <= 3'd0;
            gov_q    <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= 8'd0;
            press_q  <= 1'b0;
            state_q  <= IDLE;
            tmo_q    <= 8'd0;
            move_q   <= 3'd0;
            turns_q  <= 8'd0;
            enter_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            gov_q    <= gov_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            move_q   <= move_d;
            turns_q  <= turns_d;
            enter_q  <= enter_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign enter  = enter_q;
    assign move   = move_q;
    assign reject = reject_q;
    assign turns  = turns_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_move_entry.sv
// Bench for move_entry: directed scenarios with literal expectations plus randomized traffic against a cycle model.
`timescale 1ns/1ps
module tb_move_entry;
    localparam int DEBOUNCE = 16;
    localparam int TIMEOUT  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_ACK   = 2;
    localparam int M_REJ   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic [2:0] sw_move = 3'd0;
    logic       ready = 1'b1;
    logic       gameover = 1'b0;
    logic       enter;
    logic [2:0] move;
    logic       reject;
    logic [7:0] turns;
    logic       busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    move_entry #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_move(sw_move),
        .ready(ready), .gameover(gameover), .enter(enter), .move(move),
        .reject(reject), .turns(turns), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: delay lines for the synchronizers, a run-length for the button,
    // and a small mode variable for the handshake with the core.
    int m_b1, m_b2, m_sw1, m_sw2, m_gov;
    int m_level, m_run, m_press;
    int m_mode, m_wait, m_move, m_turns;

    task automatic model_step();
        bit gov_rise;
        bit accepted;
        if (reset) begin
            m_b1 = 0; m_b2 = 0; m_sw1 = 0; m_sw2 = 0; m_gov = 0;
            m_level = 0; m_run = 0; m_press = 0;
            m_mode = M_IDLE; m_wait = 0; m_move = 0; m_turns = 0;
        end else begin
            gov_rise = (gameover == 1'b1) && (m_gov == 0);
            accepted = 1'b0;
            case (m_mode)
                M_IDLE:
                    if (m_press != 0 && ready) begin
                        if (m_sw2 >= 1 && m_sw2 <= 5) begin
                            m_move = m_sw2; m_wait = 0; m_mode = M_DRIVE;
                        end else begin
                            m_mode = M_REJ;
                        end
                    end
                M_DRIVE:
                    if (!ready) begin
                        m_mode = M_ACK; accepted = 1'b1;
                    end else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) m_mode = M_REJ;
                    end
                M_ACK: if (ready) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
            if (gov_rise) m_turns = 0;
            else if (accepted && m_turns < 255) m_turns++;
            m_gov = int'(gameover);
            m_press = 0;
            if (m_b2 != m_level) begin
                m_run++;
                if (m_run == DEBOUNCE) begin
                    m_level = 1 - m_level;
                    m_run = 0;
                    m_press = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_b2 = m_b1; m_b1 = int'(btn_raw);
            m_sw2 = m_sw1; m_sw1 = int'(sw_move);
        end
    endtask

    always @(posedge clock) begin
        model_step();
        if (chk_en) begin
            #1;
            check("enter",  32'(enter),  (m_mode == M_DRIVE) ? 1 : 0);
            check("busy",   32'(busy),   (m_mode != M_IDLE) ? 1 : 0);
            check("reject", 32'(reject), (m_mode == M_REJ) ? 1 : 0);
            check("move",   32'(move),   m_move);
            check("turns",  32'(turns),  m_turns);
        end
    end

    int   enter_rises = 0;
    int   enter_cycles = 0;
    int   reject_cycles = 0;
    logic enter_prev = 1'b0;

    always @(posedge clock) begin
        #2;
        if (enter === 1'b1 && enter_prev !== 1'b1) enter_rises++;
        if (enter === 1'b1) enter_cycles++;
        if (reject === 1'b1) reject_cycles++;
        enter_prev = enter;
    end

    task automatic clr_counts();
        enter_rises = 0; enter_cycles = 0; reject_cycles = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_enter(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (enter === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_move(input logic [2:0] sw, input bit gov);
        bit ok;
        sw_move = sw;
        btn_raw = 1'b1;
        wait_enter(60, ok);
        check("move_enter_seen", 32'(ok), 1);
        ready = 1'b0;
        if (gov) gameover = 1'b1;
        @(negedge clock);
        ready = 1'b1;
        btn_raw = 1'b0;
        cycles(DEBOUNCE + 6);
        gameover = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len;

        cycles(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_enter", 32'(enter), 0);
        check("rst_move", 32'(move), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_turns", 32'(turns), 0);
        check("rst_busy", 32'(busy), 0);

        // Clean press of move 3, core accepts by dropping ready.
        sw_move = 3'd3; ready = 1'b1; btn_raw = 1'b1;
        wait_enter(60, ok);
        check("clean_enter_seen", 32'(ok), 1);
        check("clean_move", 32'(move), 3);
        ready = 1'b0;
        @(negedge clock);
        check("clean_enter_drop", 32'(enter), 0);
        check("clean_turns", 32'(turns), 1);
        check("clean_busy_ack", 32'(busy), 1);
        ready = 1'b1;
        @(negedge clock);
        check("clean_busy_idle", 32'(busy), 0);
        cycles(20);
        btn_raw = 1'b0;
        cycles(25);

        // Bouncing button settles high: exactly one move driven (it then times out).
        clr_counts();
        sw_move = 3'd4;
        for (int i = 0; i < 50; i++) begin
            btn_raw = ((i / 5) % 2 == 0);
            @(negedge clock);
        end
        btn_raw = 1'b1;
        cycles(40);
        check("bounce_drive_entries", 32'(enter_rises), 1);
        btn_raw = 1'b0;
        cycles(25);

        // Invalid distance: one reject pulse, no enter, turns unchanged.
        clr_counts();
        sw_move = 3'd6; btn_raw = 1'b1;
        cycles(40);
        check("inv_reject_cycles", 32'(reject_cycles), 1);
        check("inv_enter_rises", 32'(enter_rises), 0);
        check("inv_turns", 32'(turns), 1);
        btn_raw = 1'b0;
        cycles(25);

        // Core never accepts: enter for TIMEOUT cycles, then one reject.
        clr_counts();
        sw_move = 3'd2; btn_raw = 1'b1;
        cycles(45);
        check("tmo_enter_cycles", 32'(enter_cycles), 8);
        check("tmo_enter_rises", 32'(enter_rises), 1);
        check("tmo_reject_cycles", 32'(reject_cycles), 1);
        check("tmo_enter_end", 32'(enter), 0);
        check("tmo_turns", 32'(turns), 1);
        btn_raw = 1'b0;
        cycles(25);

        // Saturation at 255, then game over coincident with acceptance clears.
        for (int i = 0; i < 254; i++) do_move(3'($urandom_range(1, 5)), 1'b0);
        check("sat_reach", 32'(turns), 255);
        do_move(3'd3, 1'b0);
        check("sat_hold", 32'(turns), 255);
        do_move(3'd1, 1'b1);
        check("gov_clear", 32'(turns), 0);

        // Reset while driving a move, then a normal move.
        sw_move = 3'd5; btn_raw = 1'b1;
        wait_enter(60, ok);
        check("rd_enter_seen", 32'(ok), 1);
        reset = 1'b1; btn_raw = 1'b0;
        @(negedge clock);
        check("rd_enter", 32'(enter), 0);
        check("rd_move", 32'(move), 0);
        check("rd_reject", 32'(reject), 0);
        check("rd_turns", 32'(turns), 0);
        check("rd_busy", 32'(busy), 0);
        reset = 1'b0;
        cycles(5);
        do_move(3'd1, 1'b0);
        check("rd_after_turns", 32'(turns), 1);
        check("rd_after_move", 32'(move), 1);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 150; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            sw_move = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) ready = ~ready;
                if ($urandom_range(0, 49) == 0) gameover = ~gameover;
                if ($urandom_range(0, 15) == 0) sw_move = 3'($urandom_range(0, 7));
                reset = ($urandom_range(0, 999) == 0);
                @(negedge clock);
            end
        end
        reset = 1'b0;
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
